// File: rtl/riscv_pkg.sv
// RV32I decode vocabulary shared by the decode stage, its interface and the bench:
// instruction identifiers (inst_type) and instruction formats (fmts).
package riscv;

    typedef enum logic [5:0] {
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        FENCE, FENCE_I, ECALL, EBREAK,
        CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI
    } inst_type;

    typedef enum logic [2:0] {
        R_type, I_type, S_type, B_type, U_type, J_type
    } fmts;

endpackage

// File: rtl/rv_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the RV32I decode stage.
// slave = decode stage view, master = fetch/consumer (bench) view.
interface rv_decode_stage_if #(parameter int XLEN = 32);

    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           in_inst;
    logic [XLEN-1:0]       in_pc;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    riscv::inst_type       out_op;
    riscv::fmts            out_fmt;
    logic [4:0]            out_rd;
    logic [4:0]            out_rs1;
    logic [4:0]            out_rs2;
    logic [XLEN-1:0]       out_imm;
    logic [XLEN-1:0]       out_pc;
    logic                  out_illegal;

    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready,
        output in_ready, out_valid, out_op, out_fmt, out_rd, out_rs1, out_rs2,
               out_imm, out_pc, out_illegal
    );

    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_op, out_fmt, out_rd, out_rs1, out_rs2,
               out_imm, out_pc, out_illegal
    );

endinterface

// File: rtl/rv_decode_stage.sv
// Registered RV32I decode stage with a 1-entry skid buffer (EMPTY/ONE/FULL).
// Define RV_DECODE_ILLEGAL_EN to flag unknown encodings on out_illegal instead of emitting a NOP.
module rv_decode_stage
    import riscv::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
    input  logic                clock,
    input  logic                reset,
    rv_decode_stage_if.slave    bus
);

    typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_FULL = 2'd2} state_t;

    typedef struct packed {
        inst_type    op;
        fmts         fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        illegal;
    } dec_t;

    localparam dec_t RESET_DEC = '{op: ADDI, fmt: I_type, rd: 5'd0, rs1: 5'd0, rs2: 5'd0,
                                   imm: 32'd0, illegal: 1'b0};

    function automatic dec_t decode_word(input logic [31:0] inst);
        dec_t d;
        logic unk;
        d.op      = ADDI;
        d.fmt     = I_type;
        d.rd      = inst[11:7];
        d.rs1     = inst[19:15];
        d.rs2     = inst[24:20];
        d.imm     = {{20{inst[31]}}, inst[31:20]};
        d.illegal = 1'b0;
        unk       = 1'b0;
        case (inst[6:0])
            7'b0110111: begin d.op = LUI;   d.fmt = U_type; d.imm = {inst[31:12], 12'b0}; end
            7'b0010111: begin d.op = AUIPC; d.fmt = U_type; d.imm = {inst[31:12], 12'b0}; end
            7'b1101111: begin
                d.op  = JAL;
                d.fmt = J_type;
                d.imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            7'b1100111: begin d.op = JALR; unk = (inst[14:12] != 3'b000); end
            7'b1100011: begin
                d.fmt = B_type;
                d.imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                case (inst[14:12])
                    3'b000:  d.op = BEQ;
                    3'b001:  d.op = BNE;
                    3'b100:  d.op = BLT;
                    3'b101:  d.op = BGE;
                    3'b110:  d.op = BLTU;
                    3'b111:  d.op = BGEU;
                    default: unk  = 1'b1;
                endcase
            end
            7'b0000011: begin
                case (inst[14:12])
                    3'b000:  d.op = LB;
                    3'b001:  d.op = LH;
                    3'b010:  d.op = LW;
                    3'b100:  d.op = LBU;
                    3'b101:  d.op = LHU;
                    default: unk  = 1'b1;
                endcase
            end
            7'b0100011: begin
                d.fmt = S_type;
                d.imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                case (inst[14:12])
                    3'b000:  d.op = SB;
                    3'b001:  d.op = SH;
                    3'b010:  d.op = SW;
                    default: unk  = 1'b1;
                endcase
            end
            7'b0010011: begin
                case (inst[14:12])
                    3'b000:  d.op = ADDI;
                    3'b010:  d.op = SLTI;
                    3'b011:  d.op = SLTIU;
                    3'b100:  d.op = XORI;
                    3'b110:  d.op = ORI;
                    3'b111:  d.op = ANDI;
                    3'b001:  begin d.op = SLLI; unk = (inst[31:25] != 7'b0000000); end
                    3'b101:  begin
                        d.op = (inst[30] == 1'b1) ? SRAI : SRLI;
                        unk  = ({inst[31], inst[29:25]} != 6'b000000);
                    end
                    default: unk  = 1'b1;
                endcase
                // Shift amounts are unsigned; funct7 must not leak into the immediate.
                if ((inst[14:12] == 3'b001) || (inst[14:12] == 3'b101)) begin
                    d.imm = {27'd0, inst[24:20]};
                end else begin
                    d.imm = {{20{inst[31]}}, inst[31:20]};
                end
            end
            7'b0110011: begin
                d.fmt = R_type;
                case ({inst[31:25], inst[14:12]})
                    10'b0000000_000: d.op = ADD;
                    10'b0100000_000: d.op = SUB;
                    10'b0000000_001: d.op = SLL;
                    10'b0000000_010: d.op = SLT;
                    10'b0000000_011: d.op = SLTU;
                    10'b0000000_100: d.op = XOR;
                    10'b0000000_101: d.op = SRL;
                    10'b0100000_101: d.op = SRA;
                    10'b0000000_110: d.op = OR;
                    10'b0000000_111: d.op = AND;
                    default:         unk  = 1'b1;
                endcase
            end
            7'b0001111: begin
                d.imm = {20'd0, inst[31:20]};
                case (inst[14:12])
                    3'b000:  d.op = FENCE;
                    3'b001:  d.op = FENCE_I;
                    default: unk  = 1'b1;
                endcase
            end
            7'b1110011: begin
                // CSR address travels in imm unsigned; ECALL/EBREAK keep the plain I immediate.
                d.imm = {20'd0, inst[31:20]};
                case (inst[14:12])
                    3'b000: begin
                        d.imm = {{20{inst[31]}}, inst[31:20]};
                        case (inst[31:20])
                            12'h000: d.op = ECALL;
                            12'h001: d.op = EBREAK;
                            default: unk  = 1'b1;
                        endcase
                    end
                    3'b001:  d.op = CSRRW;
                    3'b010:  d.op = CSRRS;
                    3'b011:  d.op = CSRRC;
                    3'b101:  d.op = CSRRWI;
                    3'b110:  d.op = CSRRSI;
                    3'b111:  d.op = CSRRCI;
                    default: unk  = 1'b1;
                endcase
            end
            default: unk = 1'b1;
        endcase
        case (d.fmt)
            R_type:         d.imm = 32'd0;
            I_type:         d.rs2 = 5'd0;
            S_type, B_type: d.rd  = 5'd0;
            U_type, J_type: begin d.rs1 = 5'd0; d.rs2 = 5'd0; end
            default:        d.rs2 = 5'd0;
        endcase
        if (unk) begin
            d = RESET_DEC;
        end else begin
            d.illegal = 1'b0;
        end
`ifdef RV_DECODE_ILLEGAL_EN
        d.illegal = unk;
`else
        d.illegal = 1'b0;
`endif
        return d;
    endfunction

    state_t          state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    dec_t            out_dec_q, out_dec_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [31:0]     skid_inst_q, skid_inst_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;

    logic            in_xfer_s;
    logic            out_xfer_s;
    logic            load_out_s;
    logic [31:0]     src_inst_s;
    logic [XLEN-1:0] src_pc_s;
    dec_t            dec_s;

    // Next-state, skid capture and output-register load selection.
    always_comb begin
        in_xfer_s   = bus.in_valid & in_ready_q;
        out_xfer_s  = out_valid_q & bus.out_ready;
        state_d     = state_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;
        load_out_s  = 1'b0;
        // In FULL the skid word is the only candidate for the output register.
        src_inst_s  = (state_q == ST_FULL) ? skid_inst_q : bus.in_inst;
        src_pc_s    = (state_q == ST_FULL) ? skid_pc_q   : bus.in_pc;
        dec_s       = decode_word(src_inst_s);
        if (bus.flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer_s) begin
                        state_d    = ST_ONE;
                        load_out_s = 1'b1;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (in_xfer_s && out_xfer_s) begin
                        load_out_s = 1'b1;
                    end else if (in_xfer_s) begin
                        state_d     = ST_FULL;
                        skid_inst_d = bus.in_inst;
                        skid_pc_d   = bus.in_pc;
                    end else if (out_xfer_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (out_xfer_s) begin
                        state_d    = ST_ONE;
                        load_out_s = 1'b1;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        if (load_out_s) begin
            out_dec_d = dec_s;
            out_pc_d  = src_pc_s;
        end else begin
            out_dec_d = out_dec_q;
            out_pc_d  = out_pc_q;
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    // Pipeline, skid and handshake registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_dec_q   <= RESET_DEC;
            out_pc_q    <= RESET_PC;
            skid_inst_q <= 32'd0;
            skid_pc_q   <= {XLEN{1'b0}};
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_dec_q   <= out_dec_d;
            out_pc_q    <= out_pc_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_op      = out_dec_q.op;
    assign bus.out_fmt     = out_dec_q.fmt;
    assign bus.out_rd      = out_dec_q.rd;
    assign bus.out_rs1     = out_dec_q.rs1;
    assign bus.out_rs2     = out_dec_q.rs2;
    assign bus.out_imm     = out_dec_q.imm;
    assign bus.out_pc      = out_pc_q;
    assign bus.out_illegal = out_dec_q.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Scoreboard bench for rv_decode_stage: expected decodes are queued on input transfer and
// compared on output transfer (and every stalled cycle, for stability).
module tb_rv_decode_stage;
    import riscv::*;

    typedef struct packed {
        inst_type    op;
        fmts         fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

`ifdef RV_DECODE_ILLEGAL_EN
    localparam logic ILL_EXP = 1'b1;
`else
    localparam logic ILL_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    exp_t cur_exp;

    always #5 clk = ~clk;

    rv_decode_stage_if #(.XLEN(32)) bus ();

    rv_decode_stage #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk(input inst_type op, input fmts fmt, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, input logic [31:0] pc, input logic ill);
        exp_t e;
        e.op = op; e.fmt = fmt; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
        e.imm = imm; e.pc = pc; e.ill = ill;
        return e;
    endfunction

    task automatic compare_front(input string tag);
        exp_t e;
        e = sb_q[0];
        check_eq({tag, "_fields"},
                 64'({bus.out_op, bus.out_fmt, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_illegal}),
                 64'({e.op, e.fmt, e.rd, e.rs1, e.rs2, e.ill}));
        check_eq({tag, "_imm"}, 64'(bus.out_imm), 64'(e.imm));
        check_eq({tag, "_pc"}, 64'(bus.out_pc), 64'(e.pc));
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check_eq({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        check_eq({tag, "_fields"},
                 64'({bus.out_op, bus.out_fmt, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_illegal}),
                 64'({ADDI, I_type, 5'd0, 5'd0, 5'd0, 1'b0}));
        check_eq({tag, "_imm"}, 64'(bus.out_imm), 64'd0);
        check_eq({tag, "_pc"}, 64'(bus.out_pc), 64'd0);
    endtask

    // Scoreboard monitor: compare/pop on output side, push on accepted input.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (bus.out_valid) begin
                if (sb_q.size() == 0) begin
                    check_eq("spurious_out", 64'(bus.out_valid), 64'd0);
                end else begin
                    compare_front(bus.out_ready ? "xfer" : "stall");
                    if (bus.out_ready) void'(sb_q.pop_front());
                end
            end
            if (bus.flush) sb_q.delete();
            else if (bus.in_valid && bus.in_ready) sb_q.push_back(cur_exp);
        end
    end

    task automatic send(input logic [31:0] inst, input exp_t e);
        bit acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_pc    = e.pc;
        cur_exp      = e;
        for (int i = 0; i < 100 && !acc; i++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check_eq("send_timeout", 64'(bus.in_ready), 64'd1);
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 50 && (sb_q.size() != 0 || bus.out_valid); i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("drain_sb", 64'(sb_q.size()), 64'd0);
        check_eq("drain_out_valid", 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_inst = 32'd0; bus.in_pc = 32'd0;
        bus.flush = 1'b0; bus.out_ready = 1'b0;
        cur_exp = mk(ADDI, I_type, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_reset_vals("post_rst");

        // Streaming decode with consumer always ready (T1-T3, T6 and extras).
        bus.out_ready = 1'b1;
        send(32'hFFF00093, mk(ADDI,  I_type, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h100, 1'b0));
        send(32'h0020A423, mk(SW,    S_type, 5'd0, 5'd1, 5'd2, 32'd8,        32'h104, 1'b0));
        send(32'hFE000EE3, mk(BEQ,   B_type, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 32'h108, 1'b0));
        send(32'h123452B7, mk(LUI,   U_type, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h10C, 1'b0));
        send(32'h40D35293, mk(SRAI,  I_type, 5'd5, 5'd6, 5'd0, 32'd13,       32'h110, 1'b0));
        send(32'h002081B3, mk(ADD,   R_type, 5'd3, 5'd1, 5'd2, 32'd0,        32'h114, 1'b0));
        send(32'h402081B3, mk(SUB,   R_type, 5'd3, 5'd1, 5'd2, 32'd0,        32'h118, 1'b0));
        send(32'h008000EF, mk(JAL,   J_type, 5'd1, 5'd0, 5'd0, 32'd8,        32'h11C, 1'b0));
        send(32'h300110F3, mk(CSRRW, I_type, 5'd1, 5'd2, 5'd0, 32'h300,      32'h120, 1'b0));
        send(32'hFFC12283, mk(LW,    I_type, 5'd5, 5'd2, 5'd0, 32'hFFFFFFFC, 32'h124, 1'b0));
        send(32'h0FF0000F, mk(FENCE, I_type, 5'd0, 5'd0, 5'd0, 32'h0FF,      32'h128, 1'b0));
        send(32'h00000073, mk(ECALL, I_type, 5'd0, 5'd0, 5'd0, 32'd0,        32'h12C, 1'b0));
        send(32'h00000000, mk(ADDI,  I_type, 5'd0, 5'd0, 5'd0, 32'd0,        32'h300, ILL_EXP));
        send(32'h202081B3, mk(ADDI,  I_type, 5'd0, 5'd0, 5'd0, 32'd0,        32'h304, ILL_EXP));
        drain();

        // T4: stalled consumer, three words back-to-back.
        bus.out_ready = 1'b0;
        send(32'h00100093, mk(ADDI, I_type, 5'd1, 5'd0, 5'd0, 32'd1, 32'h400, 1'b0));
        send(32'h00200113, mk(ADDI, I_type, 5'd2, 5'd0, 5'd0, 32'd2, 32'h404, 1'b0));
        check_eq("t4_in_ready_full", 64'(bus.in_ready), 64'd0);
        check_eq("t4_out_valid_full", 64'(bus.out_valid), 64'd1);
        bus.in_inst = 32'h00300193;
        bus.in_pc   = 32'h408;
        cur_exp     = mk(ADDI, I_type, 5'd3, 5'd0, 5'd0, 32'd3, 32'h408, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_eq("t4_in_ready_stall", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        send(32'h00300193, mk(ADDI, I_type, 5'd3, 5'd0, 5'd0, 32'd3, 32'h408, 1'b0));
        drain();

        // T5: flush while FULL with a word presented.
        bus.out_ready = 1'b0;
        send(32'h00500293, mk(ADDI, I_type, 5'd5, 5'd0, 5'd0, 32'd5, 32'h500, 1'b0));
        send(32'h00600313, mk(ADDI, I_type, 5'd6, 5'd0, 5'd0, 32'd6, 32'h504, 1'b0));
        bus.in_valid = 1'b1;
        bus.in_inst  = 32'h00700393;
        bus.in_pc    = 32'h508;
        cur_exp      = mk(ADDI, I_type, 5'd7, 5'd0, 5'd0, 32'd7, 32'h508, 1'b0);
        bus.flush    = 1'b1;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check_eq("t5_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("t5_in_ready", 64'(bus.in_ready), 64'd1);
        bus.out_ready = 1'b1;
        send(32'h00800413, mk(ADDI, I_type, 5'd8, 5'd0, 5'd0, 32'd8, 32'h50C, 1'b0));
        drain();

        // Reset asserted with two entries held.
        bus.out_ready = 1'b0;
        send(32'h00900493, mk(ADDI, I_type, 5'd9, 5'd0, 5'd0, 32'd9, 32'h600, 1'b0));
        send(32'h00A00513, mk(ADDI, I_type, 5'd10, 5'd0, 5'd0, 32'd10, 32'h604, 1'b0));
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #2;
        check_reset_vals("mid_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        send(32'h00B00593, mk(ADDI, I_type, 5'd11, 5'd0, 5'd0, 32'd11, 32'h700, 1'b0));
        drain();
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
